fifo_wr_arbiter: RTL and testbench

- Round-robin write arbiter that lets NREQ independent producers share the single 8-bit write port of the 16-entry fifo block.
- Holds a local credit count of free FIFO entries, so no write is ever issued into a full FIFO. The fifo_full flag lags one cycle and is never used for flow control.
- Supports a bounded burst: a requester keeps ownership for up to MAX_BURST consecutive beats, then ownership rotates.
- Sits between the producer blocks and the fifo write_en/data_in pins.

---
 rtl/fifo_wr_arbiter.sv | 139 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: NREQ producers share one FIFO write port.
// Local credit counter keeps writes from entering a full FIFO; bursts are capped at MAX_BURST beats.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DEPTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     ack,
  input  logic                fifo_rd_pop,
  output logic                fifo_write_en,
  output logic [7:0]          fifo_data_in,
  output logic [4:0]          credits,
  output logic [2:0]          owner,
  output logic                cred_err
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t      state_q, state_d;
  logic [2:0]  owner_q, owner_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [3:0]  burst_cnt_q, burst_cnt_d;
  logic [4:0]  credits_q, credits_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  data_q, data_d;
  logic        cred_err_q, cred_err_d;

  logic [NREQ-1:0] owner_mask, others, acc_vec;
  logic            owner_req, owner_ok, accept, cred_full;
  logic [2:0]      acc_idx;

  // First requester at or after start, wrapping to the lowest index otherwise.
  function automatic logic [2:0] pick_winner(input logic [NREQ-1:0] r, input logic [2:0] start);
    logic [2:0] w;
    w = '0;
    for (int i = NREQ-1; i >= 0; i--) if (r[i]) w = 3'(i);
    for (int i = NREQ-1; i >= 0; i--) if (r[i] && i >= int'(start)) w = 3'(i);
    return w;
  endfunction

  assign owner_mask = NREQ'(1) << owner_q;
  assign owner_req  = |(req & owner_mask);
  assign others     = req & ~owner_mask;
  assign owner_ok   = (state_q == OWN) && owner_req && (burst_cnt_q < 4'(MAX_BURST));
  assign cred_full  = (credits_q == 5'(DEPTH));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    ack = '0;
    if (reset && credits_q != 5'd0) begin
      if (state_q == IDLE) begin
        if (|req) ack = NREQ'(1) << pick_winner(req, rr_ptr_q);
      end else if (owner_ok) begin
        ack = owner_mask;
      end else if (|others) begin
        ack = NREQ'(1) << pick_winner(others, rr_ptr_q);
      end else if (owner_req) begin
        ack = owner_mask;
      end
    end
  end

  assign acc_vec = req & ack;
  assign accept  = |acc_vec;

  always_comb begin
    acc_idx = '0;
    data_d  = data_q;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_vec[i]) begin
        acc_idx = 3'(i);
        data_d  = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    credits_d   = credits_q;
    wr_en_d     = accept;
    cred_err_d  = cred_err_q | (fifo_rd_pop && cred_full);

    if (accept) begin
      state_d = OWN;
      owner_d = acc_idx;
      if (acc_idx != owner_q) begin
        if (int'(acc_idx) == NREQ-1) rr_ptr_d = '0;
        else                         rr_ptr_d = acc_idx + 3'd1;
      end
      // A re-grant after the burst limit starts a fresh burst.
      if (owner_ok && acc_idx == owner_q) burst_cnt_d = burst_cnt_q + 4'd1;
      else                                burst_cnt_d = 4'd1;
      credits_d = credits_d - 5'd1;
    end else if (state_q == OWN && !(|req)) begin
      state_d = IDLE;
    end

    // A pop with every entry already free is bogus; it is ignored and flagged.
    if (fifo_rd_pop && !cred_full) credits_d = credits_d + 5'd1;
  end

  // NOTE: all state, including the data register, is reset so a pending beat is dropped on reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      credits_q   <= 5'(DEPTH);
      wr_en_q     <= 1'b0;
      data_q      <= '0;
      cred_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      credits_q   <= credits_d;
      wr_en_q     <= wr_en_d;
      data_q      <= data_d;
      cred_err_q  <= cred_err_d;
    end
  end

  assign fifo_write_en = wr_en_q;
  assign fifo_data_in  = data_q;
  assign credits       = credits_q;
  assign owner         = owner_q;
  assign cred_err      = cred_err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NREQ=4, DEPTH=16, MAX_BURST=4).
module tb_fifo_wr_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic        pop = 1'b0;
  logic [3:0]  ack;
  logic        fifo_write_en;
  logic [7:0]  fifo_data_in;
  logic [4:0]  credits;
  logic [2:0]  owner;
  logic        cred_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc;

  fifo_wr_arbiter #(.NREQ(4), .DEPTH(16), .MAX_BURST(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .req           (req),
    .req_data      (req_data),
    .ack           (ack),
    .fifo_rd_pop   (pop),
    .fifo_write_en (fifo_write_en),
    .fifo_data_in  (fifo_data_in),
    .credits       (credits),
    .owner         (owner),
    .cred_err      (cred_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_wen", 32'(fifo_write_en), 32'h0);
    check("rst_data", 32'(fifo_data_in), 32'h0);
    check("rst_credits", 32'(credits), 32'd16);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_cred_err", 32'(cred_err), 32'h0);

    // First acceptance right after release
    req = 4'b0001; req_data[7:0] = 8'hA5; reset = 1'b1;
    #1 check("first_ack", 32'(ack), 32'h1);
    tick();
    check("first_wen", 32'(fifo_write_en), 32'h1);
    check("first_data", 32'(fifo_data_in), 32'hA5);
    check("first_credits", 32'(credits), 32'd15);
    req = '0;
    tick();
    check("idle_wen", 32'(fifo_write_en), 32'h0);
    check("idle_data_hold", 32'(fifo_data_in), 32'hA5);

    // Credit exhaustion with a single requester: 15 more beats, then stall
    req = 4'b0001;
    n_acc = 0;
    for (int k = 0; k < 20; k++) begin
      req_data[7:0] = 8'(k);
      #1 if ((ack & req) != 0) n_acc++;
      tick();
    end
    check("exhaust_count", 32'(n_acc), 32'd15);
    check("exhaust_credits", 32'(credits), 32'd0);
    check("exhaust_ack", 32'(ack), 32'h0);
    check("exhaust_last_data", 32'(fifo_data_in), 32'd14);
    check("exhaust_wen", 32'(fifo_write_en), 32'h0);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("one_pop_credits", 32'(credits), 32'd1);
    req_data[7:0] = 8'h77;
    n_acc = 0;
    for (int k = 0; k < 5; k++) begin
      #1 if ((ack & req) != 0) n_acc++;
      tick();
    end
    check("one_pop_count", 32'(n_acc), 32'd1);
    check("one_pop_credits_after", 32'(credits), 32'd0);
    check("one_pop_data", 32'(fifo_data_in), 32'h77);

    // Fairness with all requesters asserted and a pop every cycle
    reset = 1'b0; req = '0;
    tick();
    req = 4'b1111; req_data = 32'h13121110; reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1 check("fair_ack", 32'(ack), 32'(4'b0001 << ((k / 4) % 4)));
      tick();
      check("fair_wen", 32'(fifo_write_en), 32'h1);
      check("fair_data", 32'(fifo_data_in), 32'(8'h10 + 8'((k / 4) % 4)));
      check("fair_credits", 32'(credits), 32'd15);
      pop = 1'b1;
    end
    req = '0; pop = 1'b0;
    tick();
    check("fair_end_credits", 32'(credits), 32'd15);
    check("fair_end_wen", 32'(fifo_write_en), 32'h0);
    check("fair_no_err", 32'(cred_err), 32'h0);

    // Owner drops mid-burst: ack moves to the other requester at once
    reset = 1'b0;
    tick();
    req = 4'b0010; req_data = 32'h33222100; reset = 1'b1;
    #1 check("drop_ack1", 32'(ack), 32'h2);
    tick();
    check("drop_owner1", 32'(owner), 32'd1);
    tick();
    req = 4'b1000;
    #1 check("drop_ack3", 32'(ack), 32'h8);
    tick();
    check("drop_owner3", 32'(owner), 32'd3);
    check("drop_data", 32'(fifo_data_in), 32'h33);
    check("drop_wen", 32'(fifo_write_en), 32'h1);
    req = '0;
    tick();
    check("drop_idle_wen", 32'(fifo_write_en), 32'h0);
    req = 4'b1111;
    #1 check("drop_rr_start0", 32'(ack), 32'h1);
    req = '0;

    // Pop with all credits free saturates and sets the sticky error
    reset = 1'b0;
    tick();
    reset = 1'b1; pop = 1'b1;
    tick();
    pop = 1'b0;
    check("sat_credits", 32'(credits), 32'd16);
    check("sat_err", 32'(cred_err), 32'h1);
    tick();
    tick();
    check("sat_err_sticky", 32'(cred_err), 32'h1);
    check("sat_credits_hold", 32'(credits), 32'd16);

    // Asynchronous reset mid-burst drops the pending beat
    req = 4'b0001; req_data[7:0] = 8'h5A;
    tick();
    check("arst_pre_wen", 32'(fifo_write_en), 32'h1);
    check("arst_pre_credits", 32'(credits), 32'd15);
    req_data[7:0] = 8'h5B;
    #1 check("arst_pre_ack", 32'(ack), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("arst_ack", 32'(ack), 32'h0);
    check("arst_wen", 32'(fifo_write_en), 32'h0);
    check("arst_credits", 32'(credits), 32'd16);
    check("arst_err_clear", 32'(cred_err), 32'h0);
    tick();
    check("arst_edge_wen", 32'(fifo_write_en), 32'h0);
    check("arst_edge_data", 32'(fifo_data_in), 32'h0);
    check("arst_edge_credits", 32'(credits), 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
